// File: rtl/regfile_result_checker.sv
// Bring-up harness: runs the core for a fixed cycle budget, freezes it,
// then checks regfile contents against a masked expectation table.
module regfile_result_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_CHECKS     = 8,
  parameter int CYCLE_LIMIT    = 100,
  parameter int CNT_WIDTH      = 16,
  parameter int STOP_ON_ERROR  = 0,
  localparam int IW = $clog2(NUM_CHECKS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      exp_wr_en,
  input  logic [IW-1:0]             exp_wr_idx,
  input  logic                      exp_wr_valid,
  input  logic [REG_ADDR_WIDTH-1:0] exp_wr_reg,
  input  logic [DATA_WIDTH-1:0]     exp_wr_data,
  input  logic [DATA_WIDTH-1:0]     exp_wr_mask,
  output logic                      dut_reset,
  output logic                      dut_clock_en,
  output logic [REG_ADDR_WIDTH-1:0] chk_read_reg,
  input  logic [DATA_WIDTH-1:0]     chk_read_data,
  output logic [CNT_WIDTH-1:0]      cycle_count,
  output logic [CNT_WIDTH-1:0]      error_count,
  output logic                      fail_valid,
  output logic [REG_ADDR_WIDTH-1:0] fail_reg,
  output logic [DATA_WIDTH-1:0]     fail_expected,
  output logic [DATA_WIDTH-1:0]     fail_read,
  output logic                      busy,
  output logic                      done,
  output logic                      pass
);

  localparam int RW = (CYCLE_LIMIT > 1) ? $clog2(CYCLE_LIMIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_ISSUE, S_CMP, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [NUM_CHECKS-1:0]     tval_q;
  logic [REG_ADDR_WIDTH-1:0] treg_q [NUM_CHECKS];
  logic [DATA_WIDTH-1:0]     tdat_q [NUM_CHECKS];
  logic [DATA_WIDTH-1:0]     tmsk_q [NUM_CHECKS];

  logic [RW-1:0]             run_q, run_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [CNT_WIDTH-1:0]      cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0]      err_q, err_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [REG_ADDR_WIDTH-1:0] freg_q, freg_d;
  logic [DATA_WIDTH-1:0]     fexp_q, fexp_d;
  logic [DATA_WIDTH-1:0]     frd_q, frd_d;

  logic idle_or_done;
  logic wr_ok;
  logic run_last;
  logic last_chk;
  logic mismatch;

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign wr_ok    = exp_wr_en && idle_or_done;
  assign run_last = (run_q == RW'(CYCLE_LIMIT - 1));
  assign last_chk = (idx_q == IW'(NUM_CHECKS - 1));
  assign mismatch = (state_q == S_CMP) && tval_q[idx_q] &&
    (|((chk_read_data ^ tdat_q[idx_q]) & tmsk_q[idx_q]));

  // Valid bits reset; payload fields only matter once valid is set.
  always_ff @(posedge clock) begin
    if (reset) begin
      tval_q <= '0;
    end else if (wr_ok) begin
      tval_q[exp_wr_idx] <= exp_wr_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      treg_q[exp_wr_idx] <= exp_wr_reg;
      tdat_q[exp_wr_idx] <= exp_wr_data;
      tmsk_q[exp_wr_idx] <= exp_wr_mask;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RUN;
      S_RUN:   if (run_last) state_d = S_ISSUE;
      S_ISSUE: state_d = S_CMP;
      S_CMP: begin
        if (last_chk || (mismatch && STOP_ON_ERROR != 0)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    run_d  = run_q;
    idx_d  = idx_q;
    cyc_d  = cyc_q;
    err_d  = err_q;
    rd_d   = rd_q;
    freg_d = freg_q;
    fexp_d = fexp_q;
    frd_d  = frd_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          run_d  = '0;
          idx_d  = '0;
          cyc_d  = '0;
          err_d  = '0;
          freg_d = '0;
          fexp_d = '0;
          frd_d  = '0;
        end
      end
      S_RUN: begin
        run_d = run_q + RW'(1);
        cyc_d = cyc_q + CNT_WIDTH'(1);
      end
      S_ISSUE: rd_d = treg_q[idx_q];
      S_CMP: begin
        if (mismatch) begin
          freg_d = rd_q;
          fexp_d = tdat_q[idx_q];
          frd_d  = chk_read_data;
          if (err_q != '1) err_d = err_q + CNT_WIDTH'(1);
        end
        if (state_d == S_ISSUE) idx_d = idx_q + IW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      run_q  <= '0;
      idx_q  <= '0;
      cyc_q  <= '0;
      err_q  <= '0;
      rd_q   <= '0;
      freg_q <= '0;
      fexp_q <= '0;
      frd_q  <= '0;
    end else begin
      run_q  <= run_d;
      idx_q  <= idx_d;
      cyc_q  <= cyc_d;
      err_q  <= err_d;
      rd_q   <= rd_d;
      freg_q <= freg_d;
      fexp_q <= fexp_d;
      frd_q  <= frd_d;
    end
  end

  // Restarting from DONE gives the core a one-cycle reset on the start edge.
  always_comb begin
    dut_reset    = 1'b0;
    dut_clock_en = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      S_IDLE: dut_reset = 1'b1;
      S_RUN: begin
        dut_clock_en = 1'b1;
        busy         = 1'b1;
      end
      S_ISSUE, S_CMP: busy = 1'b1;
      S_DONE: begin
        done      = 1'b1;
        dut_reset = start;
      end
      default: ;
    endcase
  end

  assign pass          = done && (err_q == '0);
  assign fail_valid    = mismatch;
  assign chk_read_reg  = rd_q;
  assign cycle_count   = cyc_q;
  assign error_count   = err_q;
  assign fail_reg      = freg_q;
  assign fail_expected = fexp_q;
  assign fail_read     = frd_q;

endmodule

// File: tb/tb_regfile_result_checker.sv
// Randomized and directed checks of regfile_result_checker against a
// table-walking reference model; three instances cover parameter variants.
module tb_regfile_result_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, start, wen;
  logic [2:0] widx;
  logic       wvalid;
  logic [4:0] wreg;
  logic [31:0] wdata, wmask;

  logic [2:0] dres, den, fv, busy, done, pass;
  logic [2:0][4:0]  rreg, freg;
  logic [2:0][31:0] rdata, fexp, fread;
  logic [2:0][15:0] cyc, err;
  logic [31:0] rf [32];

  // inst 0: L=10; inst 1: L=5 stop-on-error; inst 2: L=3, 2-bit counters
  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int L  = (g == 0) ? 10 : (g == 1) ? 5 : 3;
    localparam int SE = (g == 1) ? 1 : 0;
    localparam int CW = (g == 2) ? 2 : 16;
    logic [CW-1:0] cc, ec;
    assign rdata[g] = rf[rreg[g]];
    assign cyc[g] = 16'(cc);
    assign err[g] = 16'(ec);
    regfile_result_checker #(
      .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .NUM_CHECKS(8),
      .CYCLE_LIMIT(L), .CNT_WIDTH(CW), .STOP_ON_ERROR(SE)
    ) u_dut (
      .clock(clk), .reset(rst[g]), .start(start[g]),
      .exp_wr_en(wen[g]), .exp_wr_idx(widx), .exp_wr_valid(wvalid),
      .exp_wr_reg(wreg), .exp_wr_data(wdata), .exp_wr_mask(wmask),
      .dut_reset(dres[g]), .dut_clock_en(den[g]),
      .chk_read_reg(rreg[g]), .chk_read_data(rdata[g]),
      .cycle_count(cc), .error_count(ec),
      .fail_valid(fv[g]), .fail_reg(freg[g]),
      .fail_expected(fexp[g]), .fail_read(fread[g]),
      .busy(busy[g]), .done(done[g]), .pass(pass[g])
    );
  end

  int total = 0;
  int bad = 0;

  bit          mv [3][8];
  logic [4:0]  mr [3][8];
  logic [31:0] md [3][8];
  logic [31:0] mm [3][8];

  task automatic wr(input int i, input int idx, input bit v,
                    input logic [4:0] r, input logic [31:0] d,
                    input logic [31:0] m);
    @(negedge clk);
    widx = 3'(idx); wvalid = v; wreg = r; wdata = d; wmask = m;
    wen[i] = 1'b1;
    @(negedge clk);
    wen[i] = 1'b0;
    mv[i][idx] = v; mr[i][idx] = r; md[i][idx] = d; mm[i][idx] = m;
  endtask

  task automatic run(input int i, output int en_c, output int bz_c,
                     output int fv_c, output bit to);
    @(negedge clk) start[i] = 1'b1;
    @(negedge clk) start[i] = 1'b0;
    en_c = 0; bz_c = 0; fv_c = 0; to = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (done[i]) begin
        to = 1'b0;
        break;
      end
      en_c += int'(den[i]);
      bz_c += int'(busy[i]);
      fv_c += int'(fv[i]);
      @(negedge clk);
    end
  endtask

  // Walks the table in order as the spec describes the check phase.
  task automatic model(input int i, input bit stop, input int cw,
                       output int errs, output int pulses, output int checks,
                       output logic [4:0] lr, output logic [31:0] le,
                       output logic [31:0] lrd);
    errs = 0; pulses = 0; checks = 0; lr = '0; le = '0; lrd = '0;
    for (int e = 0; e < 8; e++) begin
      checks++;
      if (mv[i][e] && (((rf[mr[i][e]] ^ md[i][e]) & mm[i][e]) != 0)) begin
        pulses++;
        if (errs < (1 << cw) - 1) errs++;
        lr = mr[i][e]; le = md[i][e]; lrd = rf[mr[i][e]];
        if (stop) break;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({dres[i], den[i], busy[i], done[i], pass[i], fv[i]} !== 6'b100000) begin
        bad++;
        $display("FAIL reset_ctl[%0d] got=%b want=100000", i,
                 {dres[i], den[i], busy[i], done[i], pass[i], fv[i]});
      end
      total++;
      if ({cyc[i], err[i]} !== 32'h0) begin
        bad++;
        $display("FAIL reset_cnt[%0d] got=%h want=0", i, {cyc[i], err[i]});
      end
      total++;
      if ({freg[i], fexp[i], fread[i], rreg[i]} !== 74'h0) begin
        bad++;
        $display("FAIL reset_fail[%0d] got=%h want=0", i,
                 {freg[i], fexp[i], fread[i], rreg[i]});
      end
    end
  endtask

  task automatic test_directed_pass();
    int en, bz, pc;
    bit to;
    rf[1] = 32'd5; rf[2] = 32'd12;
    wr(0, 0, 1'b1, 5'd1, 32'd5, 32'hFFFF_FFFF);
    wr(0, 1, 1'b1, 5'd2, 32'd12, 32'hFFFF_FFFF);
    run(0, en, bz, pc, to);
    total++;
    if (to) begin bad++; $display("FAIL pass_timeout got=1 want=0"); end
    total++;
    if (en !== 10) begin bad++; $display("FAIL pass_en got=%0d want=10", en); end
    total++;
    if (bz !== 26) begin bad++; $display("FAIL pass_busy got=%0d want=26", bz); end
    total++;
    if (pc !== 0) begin bad++; $display("FAIL pass_fv got=%0d want=0", pc); end
    total++;
    if ({done[0], pass[0]} !== 2'b11) begin
      bad++; $display("FAIL pass_flags got=%b want=11", {done[0], pass[0]});
    end
    total++;
    if (err[0] !== 16'd0) begin
      bad++; $display("FAIL pass_err got=%0d want=0", err[0]);
    end
    total++;
    if (cyc[0] !== 16'd10) begin
      bad++; $display("FAIL pass_cyc got=%0d want=10", cyc[0]);
    end
    total++;
    if (dres[0] !== 1'b0) begin
      bad++; $display("FAIL pass_dres got=%b want=0", dres[0]);
    end
  endtask

  task automatic test_mismatch();
    int en, bz, pc;
    bit to;
    rf[4] = 32'h0000_ABCE;
    wr(0, 3, 1'b1, 5'd4, 32'h0000_ABCD, 32'hFFFF_FFFF);
    run(0, en, bz, pc, to);
    total++;
    if (to || pc !== 1) begin
      bad++; $display("FAIL mm_pulses got=%0d to=%0d want=1", pc, to);
    end
    total++;
    if (freg[0] !== 5'd4) begin
      bad++; $display("FAIL mm_reg got=%0d want=4", freg[0]);
    end
    total++;
    if (fexp[0] !== 32'h0000_ABCD) begin
      bad++; $display("FAIL mm_exp got=%h want=0000abcd", fexp[0]);
    end
    total++;
    if (fread[0] !== 32'h0000_ABCE) begin
      bad++; $display("FAIL mm_read got=%h want=0000abce", fread[0]);
    end
    total++;
    if (err[0] !== 16'd1 || pass[0] !== 1'b0) begin
      bad++; $display("FAIL mm_err got=%0d/%b want=1/0", err[0], pass[0]);
    end
  endtask

  task automatic test_mask();
    int en, bz, pc;
    bit to;
    wr(0, 3, 1'b1, 5'd4, 32'h0000_ABCD, 32'hFFFF_FFFC);
    run(0, en, bz, pc, to);
    total++;
    if (to || pc !== 0 || pass[0] !== 1'b1) begin
      bad++; $display("FAIL mask got=%0d/%b want=0/1", pc, pass[0]);
    end
    total++;
    if (freg[0] !== 5'd0 || fread[0] !== 32'd0) begin
      bad++; $display("FAIL mask_clr got=%0d/%h want=0/0", freg[0], fread[0]);
    end
  endtask

  task automatic test_control();
    int en, bz, pc;
    bit to, ws;
    int nb;
    // start mid-RUN and a table write during ISSUE must both be ignored
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    en = 0; bz = 0; pc = 0; to = 1'b1; ws = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done[0]) begin to = 1'b0; break; end
      en += int'(den[0]); bz += int'(busy[0]); pc += int'(fv[0]);
      start[0] = (k == 3);
      if (!den[0] && busy[0] && !ws) begin
        ws = 1'b1;
        widx = 3'd3; wvalid = 1'b1; wreg = 5'd4;
        wdata = 32'h1234; wmask = 32'hFFFF_FFFF;
        wen[0] = 1'b1;
      end else begin
        wen[0] = 1'b0;
      end
      @(negedge clk);
    end
    wen[0] = 1'b0; start[0] = 1'b0;
    total++;
    if (to || en !== 10 || bz !== 26) begin
      bad++; $display("FAIL ctl_run got=%0d/%0d want=10/26", en, bz);
    end
    total++;
    if (pc !== 0 || pass[0] !== 1'b1) begin
      bad++; $display("FAIL ctl_table got=%0d/%b want=0/1", pc, pass[0]);
    end
    // reset landing on a mismatching COMPARE
    wr(0, 0, 1'b1, 5'd4, 32'h0000_ABCD, 32'hFFFF_FFFF);
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy[0] && !den[0]) nb++;
      if (nb == 2) break;
      @(negedge clk);
    end
    total++;
    if (nb !== 2 || fv[0] !== 1'b1) begin
      bad++; $display("FAIL ctl_cmp got=%0d/%b want=2/1", nb, fv[0]);
    end
    rst[0] = 1'b1;
    @(negedge clk);
    total++;
    if ({dres[0], busy[0], done[0], fv[0]} !== 4'b1000) begin
      bad++;
      $display("FAIL ctl_rst got=%b want=1000", {dres[0], busy[0], done[0], fv[0]});
    end
    total++;
    if (cyc[0] !== 16'd0 || err[0] !== 16'd0) begin
      bad++; $display("FAIL ctl_rstcnt got=%0d/%0d want=0/0", cyc[0], err[0]);
    end
    rst[0] = 1'b0;
    for (int e = 0; e < 8; e++) mv[0][e] = 1'b0;
    run(0, en, bz, pc, to);
    total++;
    if (to || pc !== 0 || pass[0] !== 1'b1 || err[0] !== 16'd0) begin
      bad++; $display("FAIL ctl_valid got=%0d/%b want=0/1", pc, pass[0]);
    end
  endtask

  task automatic test_random();
    int en, bz, pc, xe, xp, xc;
    bit to;
    logic [4:0] xr;
    logic [31:0] xd, xrd, d, m;
    int r, sel;
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 8; k++) rf[k] = $urandom;
      for (int e = 0; e < 8; e++) begin
        r = $urandom_range(0, 7);
        sel = $urandom_range(0, 3);
        m = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF : $urandom;
        d = rf[r];
        if ($urandom_range(0, 1) == 1) d = d ^ (32'h1 << $urandom_range(0, 31));
        wr(0, e, ($urandom_range(0, 3) != 0), 5'(r), d, m);
      end
      model(0, 1'b0, 16, xe, xp, xc, xr, xd, xrd);
      run(0, en, bz, pc, to);
      total++;
      if (to || en !== 10 || bz !== 10 + 2 * xc) begin
        bad++; $display("FAIL rnd_len[%0d] got=%0d/%0d want=10/%0d", it, en, bz, 10 + 2 * xc);
      end
      total++;
      if (pc !== xp || err[0] !== 16'(xe)) begin
        bad++; $display("FAIL rnd_err[%0d] got=%0d/%0d want=%0d/%0d", it, pc, err[0], xp, xe);
      end
      total++;
      if (freg[0] !== xr || fexp[0] !== xd || fread[0] !== xrd) begin
        bad++;
        $display("FAIL rnd_fail[%0d] got=%0d/%h/%h want=%0d/%h/%h", it,
                 freg[0], fexp[0], fread[0], xr, xd, xrd);
      end
      total++;
      if (pass[0] !== (xe == 0)) begin
        bad++; $display("FAIL rnd_pass[%0d] got=%b want=%b", it, pass[0], (xe == 0));
      end
    end
  endtask

  task automatic test_stop();
    int en, bz, pc, xe, xp, xc;
    bit to;
    logic [4:0] xr;
    logic [31:0] xd, xrd;
    rf[5] = 32'd9; rf[6] = 32'd2; rf[7] = 32'd3;
    wr(1, 0, 1'b1, 5'd5, 32'd9, 32'hFFFF_FFFF);
    wr(1, 1, 1'b1, 5'd6, 32'd1, 32'hFFFF_FFFF);
    wr(1, 2, 1'b1, 5'd7, 32'd0, 32'hFFFF_FFFF);
    model(1, 1'b1, 16, xe, xp, xc, xr, xd, xrd);
    run(1, en, bz, pc, to);
    total++;
    if (to || err[1] !== 16'd1 || pc !== 1) begin
      bad++; $display("FAIL stop_err got=%0d/%0d want=1/1", err[1], pc);
    end
    total++;
    if (freg[1] !== 5'd6 || fexp[1] !== 32'd1 || fread[1] !== 32'd2) begin
      bad++; $display("FAIL stop_reg got=%0d/%h/%h want=6/1/2", freg[1], fexp[1], fread[1]);
    end
    total++;
    if (bz - en !== 4 || bz - en !== 2 * xc) begin
      bad++; $display("FAIL stop_len got=%0d want=4", bz - en);
    end
    total++;
    if (pass[1] !== 1'b0 || en !== 5) begin
      bad++; $display("FAIL stop_flags got=%b/%0d want=0/5", pass[1], en);
    end
  endtask

  task automatic test_saturation();
    int en, bz, pc, xe, xp, xc;
    bit to;
    logic [4:0] xr;
    logic [31:0] xd, xrd;
    for (int e = 0; e < 5; e++) begin
      rf[8 + e] = 32'(e);
      wr(2, e, 1'b1, 5'(8 + e), 32'(e + 100), 32'hFFFF_FFFF);
    end
    model(2, 1'b0, 2, xe, xp, xc, xr, xd, xrd);
    run(2, en, bz, pc, to);
    total++;
    if (to || err[2] !== 16'd3 || err[2] !== 16'(xe) || pc !== xp) begin
      bad++; $display("FAIL sat_err got=%0d/%0d want=3/%0d", err[2], pc, xp);
    end
    total++;
    if (cyc[2] !== 16'd3 || pass[2] !== 1'b0 || freg[2] !== xr) begin
      bad++; $display("FAIL sat_misc got=%0d/%b/%0d want=3/0/%0d", cyc[2], pass[2], freg[2], xr);
    end
    @(negedge clk) start[2] = 1'b1;
    #1;
    total++;
    if (dres[2] !== 1'b1) begin
      bad++; $display("FAIL sat_dres got=%b want=1", dres[2]);
    end
    @(negedge clk) start[2] = 1'b0;
    total++;
    if (err[2] !== 16'd0 || busy[2] !== 1'b1 || dres[2] !== 1'b0) begin
      bad++; $display("FAIL sat_clr got=%0d/%b/%b want=0/1/0", err[2], busy[2], dres[2]);
    end
    pc = 0; to = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (done[2]) begin to = 1'b0; break; end
      pc += int'(fv[2]);
      @(negedge clk);
    end
    total++;
    if (to || pc !== 5 || err[2] !== 16'd3) begin
      bad++; $display("FAIL sat_rerun got=%0d/%0d want=5/3", pc, err[2]);
    end
  endtask

  initial begin
    rst = 3'b111; start = '0; wen = '0;
    widx = '0; wvalid = 1'b0; wreg = '0; wdata = '0; wmask = '0;
    for (int k = 0; k < 32; k++) rf[k] = '0;
    for (int i = 0; i < 3; i++)
      for (int e = 0; e < 8; e++) begin
        mv[i][e] = 1'b0; mr[i][e] = '0; md[i][e] = '0; mm[i][e] = '0;
      end
    repeat (3) @(negedge clk);
    test_reset();
    rst = 3'b000;
    @(negedge clk);
    test_directed_pass();
    test_mismatch();
    test_mask();
    test_control();
    test_random();
    test_stop();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
